// File: rtl/tpx3_rx_arbiter.sv
// Round-robin merge of the per-lane Timepix3 receiver FIFOs into one tagged word stream.
// Grants are bounded bursts; a one-entry output register decouples the downstream handshake.
module tpx3_rx_arbiter #(
    parameter int NCH        = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      BUS_CLK,
    input  logic                      BUS_RST,
    input  logic [NCH-1:0]            ENABLE_MASK,
    input  logic [NCH-1:0]            IN_EMPTY,
    input  logic [NCH*DATA_WIDTH-1:0] IN_DATA,
    output logic [NCH-1:0]            IN_READ,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [DATA_WIDTH-1:0]     OUT_DATA,
    output logic [3:0]                OUT_CH,
    output logic                      BUSY,
    output logic [CNT_WIDTH-1:0]      WORD_CNT
);

    // state    | meaning
    // ST_IDLE  | no grant; pick next requester after last_q (one-cycle arbitration)
    // ST_GRANT | popping channel grant_q until burst limit or channel runs dry

    localparam int              CHW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CHW-1:0]  LAST_RST   = CHW'(NCH - 1);
    localparam logic [7:0]      BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t                  state_q;
    logic [CHW-1:0]          grant_q;
    logic [CHW-1:0]          last_q;
    logic [7:0]              burst_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [3:0]              out_ch_q;
    logic [CNT_WIDTH-1:0]    word_cnt_q;

    logic [NCH-1:0]          req;
    logic                    slot_free;
    logic                    xfer;
    logic                    pop;
    logic                    any_req;
    logic [CHW-1:0]          grant_d;
    logic [CHW-1:0]          cand;
    logic [DATA_WIDTH-1:0]   head;
    int                      idx;

    assign req       = ENABLE_MASK & ~IN_EMPTY;
    assign xfer      = out_valid_q & OUT_READY;
    assign slot_free = ~out_valid_q | OUT_READY;

    // Pops are gated during reset so a word is never taken from a FIFO and then thrown away.
    assign pop = (state_q == ST_GRANT) & ~BUS_RST & req[grant_q] & slot_free
                 & (burst_q < BURST_MAX);

    always_comb begin
        IN_READ = '0;
        if (pop) begin
            IN_READ[grant_q] = 1'b1;
        end
    end

    always_comb begin
        grant_d = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!any_req) begin
                idx  = (int'(last_q) + k) % NCH;
                cand = CHW'(idx);
                if (req[cand]) begin
                    any_req = 1'b1;
                    grant_d = cand;
                end
            end
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_q == CHW'(i)) begin
                head = IN_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= LAST_RST;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            word_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_d;
                        burst_q <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (pop) begin
                        burst_q <= burst_q + 8'd1;
                        if (burst_q == BURST_LAST) begin
                            state_q <= ST_IDLE;
                            last_q  <= grant_q;
                        end
                    end else if (!req[grant_q]) begin
                        // Lane drained or disabled: release even if the output is stalled.
                        state_q <= ST_IDLE;
                        last_q  <= grant_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= head;
                out_ch_q    <= 4'(grant_q);
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end

            if (xfer) begin
                word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign BUSY      = (state_q == ST_GRANT) | out_valid_q;
    assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_tpx3_rx_arbiter.sv
// Directed bench for tpx3_rx_arbiter: FWFT FIFO models per lane, per-cycle vector table,
// and hand sequences for rotation, masking, mid-burst reset and counter wrap.
module tb_tpx3_rx_arbiter;

    localparam int NCH = 8;
    localparam int DW  = 32;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST = 1'b1;
    logic [NCH-1:0]    ENABLE_MASK = '0;
    logic [NCH-1:0]    IN_EMPTY;
    logic [NCH*DW-1:0] IN_DATA;
    logic [NCH-1:0]    IN_READ;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b0;
    logic [DW-1:0]     OUT_DATA;
    logic [3:0]        OUT_CH;
    logic              BUSY;
    logic [31:0]       WORD_CNT;

    logic [1:0]        w_mask = '0;
    logic [1:0]        w_empty;
    logic [63:0]       w_in;
    logic [1:0]        w_read;
    logic              w_vld;
    logic              w_ready = 1'b0;
    logic [31:0]       w_data;
    logic [3:0]        w_ch;
    logic              w_busy;
    logic [3:0]        w_cnt;

    assign w_empty = 2'b00;
    assign w_in    = 64'h0000_0055_0000_00AA;

    tpx3_rx_arbiter u_dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .ENABLE_MASK (ENABLE_MASK),
        .IN_EMPTY    (IN_EMPTY),
        .IN_DATA     (IN_DATA),
        .IN_READ     (IN_READ),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_DATA    (OUT_DATA),
        .OUT_CH      (OUT_CH),
        .BUSY        (BUSY),
        .WORD_CNT    (WORD_CNT)
    );

    tpx3_rx_arbiter #(.NCH(2), .DATA_WIDTH(32), .MAX_BURST(4), .CNT_WIDTH(4)) u_wrap (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .ENABLE_MASK (w_mask),
        .IN_EMPTY    (w_empty),
        .IN_DATA     (w_in),
        .IN_READ     (w_read),
        .OUT_VALID   (w_vld),
        .OUT_READY   (w_ready),
        .OUT_DATA    (w_data),
        .OUT_CH      (w_ch),
        .BUSY        (w_busy),
        .WORD_CNT    (w_cnt)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    logic [31:0] mem [NCH][64];
    int          wp [NCH];
    int          rp [NCH];

    always_comb begin
        IN_EMPTY = '0;
        IN_DATA  = '0;
        for (int i = 0; i < NCH; i++) begin
            IN_EMPTY[i]          = (wp[i] == rp[i]);
            IN_DATA[i*DW +: DW]  = mem[i][rp[i] % 64];
        end
    end

    typedef struct {
        logic        rdy;
        logic [7:0]  rd;
        logic        vld;
        logic [31:0] data;
        logic [3:0]  ch;
        logic        busy;
        logic [31:0] cnt;
    } vec_t;

    vec_t        tab [26];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          base = 0;
    int          pop_cnt [NCH];
    int          last_pop [NCH];
    logic [3:0]  log_ch [$];
    logic [31:0] log_data [$];

    function automatic logic [31:0] wd(input int ch, input int n);
        return 32'hA000_0000 | 32'(ch << 16) | 32'(n);
    endfunction

    function automatic vec_t mk(input logic rdy, input logic [7:0] rd, input logic vld,
                                input logic [31:0] data, input logic [3:0] ch,
                                input logic busy, input logic [31:0] cnt);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.vld = vld; v.data = data;
        v.ch = ch; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_n(input int ch, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            mem[ch][wp[ch] % 64] = wd(ch, n);
            wp[ch]++;
        end
    endtask

    task automatic ticker();
        forever begin
            @(posedge BUS_CLK);
            cyc++;
        end
    endtask

    task automatic fifo_pop();
        logic [NCH-1:0] r;
        forever begin
            @(negedge BUS_CLK);
            r = IN_READ;
            @(posedge BUS_CLK);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (r[i] && rp[i] < wp[i]) rp[i]++;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge BUS_CLK);
            if (!BUS_RST) begin
                checks++;
                if ($countones(IN_READ) > 1 || (IN_READ & IN_EMPTY) != 0 ||
                    (IN_READ & ~ENABLE_MASK) != 0 ||
                    (IN_READ != 0 && OUT_VALID && !OUT_READY)) begin
                    failures++;
                    $display("FAIL in_read_rule: cycle %0d in_read=%b empty=%b mask=%b valid=%b ready=%b",
                             cyc, IN_READ, IN_EMPTY, ENABLE_MASK, OUT_VALID, OUT_READY);
                end
                for (int i = 0; i < NCH; i++) begin
                    if (IN_READ[i]) begin
                        pop_cnt[i]++;
                        last_pop[i] = cyc;
                    end
                end
                if (OUT_VALID && OUT_READY) begin
                    log_ch.push_back(OUT_CH);
                    log_data.push_back(OUT_DATA);
                end
            end
        end
    endtask

    task automatic reset_dut();
        BUS_RST     = 1'b1;
        ENABLE_MASK = '0;
        OUT_READY   = 1'b0;
        w_mask      = '0;
        w_ready     = 1'b0;
        repeat (2) @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < NCH; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            pop_cnt[i] = 0;
            last_pop[i] = -1;
        end
        log_ch.delete();
        log_data.delete();
        BUS_RST = 1'b0;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            OUT_READY = tab[k].rdy;
            @(negedge BUS_CLK);
            chk($sformatf("vec%0d.in_read", k), 32'(IN_READ), 32'(tab[k].rd));
            chk($sformatf("vec%0d.valid", k), 32'(OUT_VALID), 32'(tab[k].vld));
            if (tab[k].vld) begin
                chk($sformatf("vec%0d.data", k), OUT_DATA, tab[k].data);
                chk($sformatf("vec%0d.ch", k), 32'(OUT_CH), 32'(tab[k].ch));
            end
            chk($sformatf("vec%0d.busy", k), 32'(BUSY), 32'(tab[k].busy));
            chk($sformatf("vec%0d.cnt", k), WORD_CNT, tab[k].cnt);
            @(posedge BUS_CLK);
            #1;
        end
    endtask

    initial begin
        int exp_ch [20];
        int seg_ch [5];
        int seg_len [5];
        int nxt [NCH];
        int k;
        int n;
        int others;

        // Single lane: channel 2, three words, ready always high.
        tab[0]  = mk(1, 8'h00, 0, 32'h0,    4'd0, 0, 0);
        tab[1]  = mk(1, 8'h04, 0, 32'h0,    4'd0, 1, 0);
        tab[2]  = mk(1, 8'h04, 1, wd(2, 0), 4'd2, 1, 0);
        tab[3]  = mk(1, 8'h04, 1, wd(2, 1), 4'd2, 1, 1);
        tab[4]  = mk(1, 8'h00, 1, wd(2, 2), 4'd2, 1, 2);
        tab[5]  = mk(1, 8'h00, 0, 32'h0,    4'd0, 0, 3);
        // Backpressure: channel 1, six words, ready high every third cycle.
        tab[6]  = mk(1, 8'h00, 0, 32'h0,    4'd0, 0, 0);
        tab[7]  = mk(0, 8'h02, 0, 32'h0,    4'd0, 1, 0);
        tab[8]  = mk(0, 8'h00, 1, wd(1, 0), 4'd1, 1, 0);
        tab[9]  = mk(1, 8'h02, 1, wd(1, 0), 4'd1, 1, 0);
        tab[10] = mk(0, 8'h00, 1, wd(1, 1), 4'd1, 1, 1);
        tab[11] = mk(0, 8'h00, 1, wd(1, 1), 4'd1, 1, 1);
        tab[12] = mk(1, 8'h02, 1, wd(1, 1), 4'd1, 1, 1);
        tab[13] = mk(0, 8'h00, 1, wd(1, 2), 4'd1, 1, 2);
        tab[14] = mk(0, 8'h00, 1, wd(1, 2), 4'd1, 1, 2);
        tab[15] = mk(1, 8'h02, 1, wd(1, 2), 4'd1, 1, 2);
        tab[16] = mk(0, 8'h00, 1, wd(1, 3), 4'd1, 1, 3);
        tab[17] = mk(0, 8'h00, 1, wd(1, 3), 4'd1, 1, 3);
        tab[18] = mk(1, 8'h02, 1, wd(1, 3), 4'd1, 1, 3);
        tab[19] = mk(0, 8'h00, 1, wd(1, 4), 4'd1, 1, 4);
        tab[20] = mk(0, 8'h00, 1, wd(1, 4), 4'd1, 1, 4);
        tab[21] = mk(1, 8'h02, 1, wd(1, 4), 4'd1, 1, 4);
        tab[22] = mk(0, 8'h00, 1, wd(1, 5), 4'd1, 1, 5);
        tab[23] = mk(0, 8'h00, 1, wd(1, 5), 4'd1, 1, 5);
        tab[24] = mk(1, 8'h00, 1, wd(1, 5), 4'd1, 1, 5);
        tab[25] = mk(1, 8'h00, 0, 32'h0,    4'd0, 0, 6);

        for (int i = 0; i < NCH; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end

        fork
            ticker();
            fifo_pop();
            monitor();
        join_none

        reset_dut();
        @(negedge BUS_CLK);
        chk("rst.valid", 32'(OUT_VALID), 32'd0);
        chk("rst.in_read", 32'(IN_READ), 32'd0);
        chk("rst.busy", 32'(BUSY), 32'd0);
        chk("rst.cnt", WORD_CNT, 32'd0);
        chk("rst.ch", 32'(OUT_CH), 32'd0);
        chk("rst.data", OUT_DATA, 32'd0);
        @(posedge BUS_CLK);
        #1;

        ENABLE_MASK = 8'h04;
        push_n(2, 3);
        run_table(0, 5);

        reset_dut();
        ENABLE_MASK = 8'h02;
        push_n(1, 6);
        run_table(6, 25);
        chk("bp.log_size", 32'(log_data.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_data.size(); i++)
            chk($sformatf("bp.order%0d", i), log_data[i], wd(1, i));

        // Rotation between lanes 0 and 3.
        reset_dut();
        ENABLE_MASK = 8'b0000_1001;
        OUT_READY   = 1'b1;
        push_n(0, 10);
        push_n(3, 10);
        base = cyc;
        repeat (32) @(posedge BUS_CLK);
        #1;
        @(negedge BUS_CLK);
        exp_ch = '{0,0,0,0,3,3,3,3,0,0,0,0,3,3,3,3,0,0,3,3};
        for (int i = 0; i < NCH; i++) nxt[i] = 0;
        chk("rot.log_size", 32'(log_ch.size()), 32'd20);
        for (int i = 0; i < 20 && i < log_ch.size(); i++) begin
            chk($sformatf("rot.ch%0d", i), 32'(log_ch[i]), 32'(exp_ch[i]));
            chk($sformatf("rot.data%0d", i), log_data[i], wd(exp_ch[i], nxt[exp_ch[i]]));
            nxt[exp_ch[i]]++;
        end
        chk("rot.cnt", WORD_CNT, 32'd20);
        chk("rot.last_pop0", 32'(last_pop[0] - base), 32'd22);
        chk("rot.last_pop3", 32'(last_pop[3] - base), 32'd26);
        chk("rot.busy", 32'(BUSY), 32'd0);
        @(posedge BUS_CLK);
        #1;

        // Mask 5/7, then drop lane 7 one pop into its second burst.
        reset_dut();
        ENABLE_MASK = 8'hA0;
        OUT_READY   = 1'b1;
        for (int c = 0; c < NCH; c++) push_n(c, 12);
        base = cyc;
        repeat (17) @(posedge BUS_CLK);
        #1;
        ENABLE_MASK = 8'h20;
        repeat (15) @(posedge BUS_CLK);
        #1;
        @(negedge BUS_CLK);
        others = 0;
        for (int i = 0; i < NCH; i++)
            if (i != 5 && i != 7) others += pop_cnt[i];
        chk("mask.other_pops", 32'(others), 32'd0);
        chk("mask.pops5", 32'(pop_cnt[5]), 32'd12);
        chk("mask.pops7", 32'(pop_cnt[7]), 32'd5);
        chk("mask.last_pop7", 32'(last_pop[7] - base), 32'd16);
        seg_ch  = '{5, 7, 5, 7, 5};
        seg_len = '{4, 4, 4, 1, 4};
        for (int i = 0; i < NCH; i++) nxt[i] = 0;
        chk("mask.log_size", 32'(log_ch.size()), 32'd17);
        k = 0;
        for (int s = 0; s < 5; s++) begin
            for (int j = 0; j < seg_len[s]; j++) begin
                if (k < log_ch.size()) begin
                    chk($sformatf("mask.ch%0d", k), 32'(log_ch[k]), 32'(seg_ch[s]));
                    chk($sformatf("mask.data%0d", k), log_data[k], wd(seg_ch[s], nxt[seg_ch[s]]));
                end
                nxt[seg_ch[s]]++;
                k++;
            end
        end
        @(posedge BUS_CLK);
        #1;

        // Reset while lane 4 is granted with a word held.
        reset_dut();
        ENABLE_MASK = 8'hFF;
        OUT_READY   = 1'b1;
        push_n(4, 6);
        @(posedge BUS_CLK);
        #1;
        @(negedge BUS_CLK);
        chk("mrst.c1_read", 32'(IN_READ), 32'h10);
        @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b1;
        push_n(0, 3);
        push_n(6, 3);
        @(negedge BUS_CLK);
        chk("mrst.c2_valid", 32'(OUT_VALID), 32'd1);
        chk("mrst.c2_ch", 32'(OUT_CH), 32'd4);
        chk("mrst.c2_busy", 32'(BUSY), 32'd1);
        @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b0;
        @(negedge BUS_CLK);
        chk("mrst.c3_valid", 32'(OUT_VALID), 32'd0);
        chk("mrst.c3_cnt", WORD_CNT, 32'd0);
        chk("mrst.c3_busy", 32'(BUSY), 32'd0);
        chk("mrst.c3_read", 32'(IN_READ), 32'd0);
        @(posedge BUS_CLK);
        #1;
        @(negedge BUS_CLK);
        chk("mrst.c4_read", 32'(IN_READ), 32'h01);
        @(posedge BUS_CLK);
        #1;
        @(negedge BUS_CLK);
        chk("mrst.c5_valid", 32'(OUT_VALID), 32'd1);
        chk("mrst.c5_ch", 32'(OUT_CH), 32'd0);
        chk("mrst.c5_data", OUT_DATA, wd(0, 0));
        @(posedge BUS_CLK);
        #1;

        // 4-bit word counter wraps after 16 transfers.
        reset_dut();
        w_mask  = 2'b01;
        w_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 200 && n < 18; t++) begin
            @(negedge BUS_CLK);
            if (w_vld && w_ready) n++;
            if (n < 18) begin
                @(posedge BUS_CLK);
                #1;
            end
        end
        @(posedge BUS_CLK);
        #1;
        w_ready = 1'b0;
        w_mask  = 2'b00;
        @(negedge BUS_CLK);
        chk("wrap.transfers", 32'(n), 32'd18);
        chk("wrap.cnt", 32'(w_cnt), 32'd2);
        chk("wrap.ch", 32'(w_ch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
